// File: rtl/network_if_pkg.sv
// Shared layout of the packed network-interface word: field offsets and counter widths.
// Word fields, LSB to MSB: flit, flit type, broadcast, virtual network id.
// No logic; constants and helper functions only.
package network_if_pkg;

    localparam int DefaultFlitWidth      = 64;
    localparam int DefaultFlitTypeWidth  = 2;
    localparam int DefaultBroadcastWidth = 1;
    localparam int DefaultVnIdWidth      = 2;
    localparam int DropCountWidth        = 16;

    function automatic int flit_type_lsb(input int flit_w);
        return flit_w;
    endfunction

    function automatic int broadcast_lsb(input int flit_w, input int type_w);
        return flit_w + type_w;
    endfunction

    function automatic int vn_id_lsb(input int flit_w, input int type_w, input int bcast_w);
        return flit_w + type_w + bcast_w;
    endfunction

    function automatic int field_msb(input int lsb, input int width);
        return lsb + width - 1;
    endfunction

    function automatic int data_width(input int flit_w, input int type_w,
                                      input int bcast_w, input int vn_w);
        return flit_w + type_w + bcast_w + vn_w;
    endfunction

endpackage

// File: rtl/network_vn_fifo.sv
// Generic synchronous circular-buffer FIFO with occupancy count.
// Latency: a push is visible at data_o the cycle after the edge that wrote it.
// Backpressure: pushes while full and pops while empty are ignored; full is registered-state only.
module network_vn_fifo #(
    parameter int Width      = 8,
    parameter int Depth      = 4,
    parameter int CountWidth = $clog2(Depth + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [Width-1:0]      data_i,
    input  logic                  pop_i,
    output logic [Width-1:0]      data_o,
    output logic                  full_o,
    output logic [CountWidth-1:0] count_o
);

    localparam int PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

    logic [Width-1:0]      mem [Depth];
    logic [PtrWidth-1:0]   wr_ptr;
    logic [PtrWidth-1:0]   rd_ptr;
    logic [CountWidth-1:0] count;
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (count == CountWidth'(Depth));
    assign count_o = count;
    assign data_o  = mem[rd_ptr];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (count != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; count gates its visibility.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/network_signal_vn_unpacker.sv
// Splits the packed ingress word into one FIFO per virtual network; illegal ids are dropped and counted.
// Latency: one cycle from accept to per-VN valid; no combinational input-to-output path.
// Backpressure: ready follows only the addressed VN's registered full flag, so VNs never block each other.
module network_signal_vn_unpacker
    import network_if_pkg::*;
#(
    parameter int NetworkIfFlitWidth             = DefaultFlitWidth,
    parameter int NetworkIfFlitTypeWidth         = DefaultFlitTypeWidth,
    parameter int NetworkIfBroadcastWidth        = DefaultBroadcastWidth,
    parameter int NetworkIfVirtualNetworkIdWidth = DefaultVnIdWidth,
    parameter int NumVirtualNetworks             = 3,
    parameter int FifoDepth                      = 4,
    localparam int NetworkIfDataWidth = data_width(NetworkIfFlitWidth, NetworkIfFlitTypeWidth,
                                                   NetworkIfBroadcastWidth,
                                                   NetworkIfVirtualNetworkIdWidth),
    localparam int CountWidth = $clog2(FifoDepth + 1)
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic                                             network_valid_i,
    output logic                                             network_ready_o,
    input  logic [NetworkIfDataWidth-1:0]                    network_data_i,
    output logic [NumVirtualNetworks-1:0]                    network_valid_o,
    input  logic [NumVirtualNetworks-1:0]                    network_ready_i,
    output logic [NumVirtualNetworks*NetworkIfFlitWidth-1:0] network_flit_o,
    output logic [NumVirtualNetworks*NetworkIfFlitTypeWidth-1:0]  network_flit_type_o,
    output logic [NumVirtualNetworks*NetworkIfBroadcastWidth-1:0] network_broadcast_o,
    output logic [NumVirtualNetworks*CountWidth-1:0]         network_occupancy_o,
    output logic                                             network_vn_error_o,
    output logic [DropCountWidth-1:0]                        network_drop_count_o
);

    localparam int VnW       = NetworkIfVirtualNetworkIdWidth;
    localparam int TypeLsb   = flit_type_lsb(NetworkIfFlitWidth);
    localparam int BcastLsb  = broadcast_lsb(NetworkIfFlitWidth, NetworkIfFlitTypeWidth);
    localparam int VnLsb     = vn_id_lsb(NetworkIfFlitWidth, NetworkIfFlitTypeWidth,
                                         NetworkIfBroadcastWidth);
    localparam int VnMsb     = field_msb(VnLsb, VnW);
    localparam int PayloadW  = VnLsb;

    logic [VnW-1:0]                vn;
    logic                          vn_legal;
    logic                          sel_full;
    logic                          accept;
    logic                          drop;
    logic [NumVirtualNetworks-1:0] full;
    logic [NumVirtualNetworks-1:0] push;
    logic [NumVirtualNetworks-1:0] pop;
    logic                          vn_error;
    logic [DropCountWidth-1:0]     drop_count;

    assign vn       = network_data_i[VnMsb:VnLsb];
    assign vn_legal = ({1'b0, vn} < (VnW + 1)'(NumVirtualNetworks));

    always_comb begin
        sel_full = 1'b0;
        for (int k = 0; k < NumVirtualNetworks; k++) begin
            if (vn == VnW'(k)) sel_full = full[k];
        end
    end

    // Illegal ids are always accepted so a bad word can never wedge the ingress.
    assign network_ready_o = vn_legal ? !sel_full : 1'b1;
    assign accept          = network_valid_i && network_ready_o;
    assign drop            = accept && !vn_legal;

    for (genvar k = 0; k < NumVirtualNetworks; k++) begin : g_vn
        logic [PayloadW-1:0]   head;
        logic [CountWidth-1:0] count;

        assign push[k] = accept && (vn == VnW'(k));
        assign pop[k]  = network_valid_o[k] && network_ready_i[k];

        network_vn_fifo #(
            .Width      (PayloadW),
            .Depth      (FifoDepth),
            .CountWidth (CountWidth)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (push[k]),
            .data_i  (network_data_i[PayloadW-1:0]),
            .pop_i   (pop[k]),
            .data_o  (head),
            .full_o  (full[k]),
            .count_o (count)
        );

        assign network_valid_o[k] = (count != '0);
        assign network_occupancy_o[k*CountWidth +: CountWidth] = count;
        assign network_flit_o[k*NetworkIfFlitWidth +: NetworkIfFlitWidth] =
            head[NetworkIfFlitWidth-1:0];
        assign network_flit_type_o[k*NetworkIfFlitTypeWidth +: NetworkIfFlitTypeWidth] =
            head[TypeLsb +: NetworkIfFlitTypeWidth];
        assign network_broadcast_o[k*NetworkIfBroadcastWidth +: NetworkIfBroadcastWidth] =
            head[BcastLsb +: NetworkIfBroadcastWidth];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vn_error   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            vn_error <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
        end
    end

    assign network_vn_error_o   = vn_error;
    assign network_drop_count_o = drop_count;

endmodule

// File: tb/tb_network_signal_vn_unpacker.sv
// Directed table of per-cycle vectors, reset sequences and a queue-model stress run for the VN unpacker.
module tb_network_signal_vn_unpacker;

    localparam int NV = 3;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_vld;
    logic              in_rdy;
    logic [68:0]       in_dat;
    logic [NV-1:0]     out_vld;
    logic [NV-1:0]     out_rdy;
    logic [NV*64-1:0]  flit_o;
    logic [NV*2-1:0]   type_o;
    logic [NV-1:0]     bcast_o;
    logic [NV*CW-1:0]  occ_o;
    logic              err_o;
    logic [15:0]       drop_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    network_signal_vn_unpacker #(
        .NumVirtualNetworks (NV),
        .FifoDepth          (4)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .network_valid_i      (in_vld),
        .network_ready_o      (in_rdy),
        .network_data_i       (in_dat),
        .network_valid_o      (out_vld),
        .network_ready_i      (out_rdy),
        .network_flit_o       (flit_o),
        .network_flit_type_o  (type_o),
        .network_broadcast_o  (bcast_o),
        .network_occupancy_o  (occ_o),
        .network_vn_error_o   (err_o),
        .network_drop_count_o (drop_o)
    );

    typedef struct {
        logic        v;
        logic [1:0]  vn;
        logic [63:0] flit;
        logic [2:0]  rdy;
        logic        e_ready;
        logic [2:0]  e_valid;
        logic [8:0]  e_occ;
        logic        ck;
        logic [1:0]  ck_vn;
        logic [63:0] e_flit;
        logic        e_err;
        logic [15:0] e_drop;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic v, input logic [1:0] vn, input logic [63:0] flit,
                                input logic [2:0] rdy, input logic e_ready, input logic [2:0] e_valid,
                                input logic [2:0] o0, input logic [2:0] o1, input logic [2:0] o2,
                                input logic ck, input logic [1:0] ck_vn, input logic [63:0] e_flit,
                                input logic e_err, input logic [15:0] e_drop);
        vec_t r;
        r.v = v; r.vn = vn; r.flit = flit; r.rdy = rdy; r.e_ready = e_ready;
        r.e_valid = e_valid; r.e_occ = {o2, o1, o0}; r.ck = ck; r.ck_vn = ck_vn;
        r.e_flit = e_flit; r.e_err = e_err; r.e_drop = e_drop;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Flit type and broadcast are derived from the flit so head checks need no extra columns.
    task automatic drive(input logic v, input logic [1:0] vn, input logic [63:0] flit,
                         input logic [2:0] rdy);
        in_vld  = v;
        in_dat  = {vn, flit[4], flit[1:0], flit};
        out_rdy = rdy;
    endtask

    task automatic chk_head(input string nm, input int k, input logic [63:0] e_flit);
        chk({nm, "_flit"},  flit_o[k*64 +: 64], e_flit);
        chk({nm, "_type"},  {62'd0, type_o[k*2 +: 2]}, {62'd0, e_flit[1:0]});
        chk({nm, "_bcast"}, {63'd0, bcast_o[k]}, {63'd0, e_flit[4]});
    endtask

    logic [63:0] q [NV][$];

    initial begin
        int unsigned seq;
        int          drops;

        rst = 1'b1;
        drive(1'b0, 2'd0, 64'd0, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {61'd0, out_vld}, 64'd0);
        chk("rst_occ",   {55'd0, occ_o}, 64'd0);
        chk("rst_err",   {63'd0, err_o}, 64'd0);
        chk("rst_drop",  {48'd0, drop_o}, 64'd0);
        rst = 1'b0;
        drive(1'b0, 2'd3, 64'd0, 3'b000);
        #1;
        chk("rst_ready_vn3", {63'd0, in_rdy}, 64'd1);
        drive(1'b0, 2'd0, 64'd0, 3'b000);
        #1;
        chk("rst_ready_vn0", {63'd0, in_rdy}, 64'd1);
        @(posedge clk);
        #1;

        //            v  vn flit    rdy     rdy val     o0 o1 o2  ck vn flit     err drop
        vecs[0]  = mk(1, 1, 64'hA5, 3'b000, 1, 3'b010, 0, 1, 0, 1, 1, 64'hA5, 0, 0);
        vecs[1]  = mk(0, 0, 64'h00, 3'b010, 1, 3'b000, 0, 0, 0, 0, 0, 64'h00, 0, 0);
        vecs[2]  = mk(1, 0, 64'h10, 3'b000, 1, 3'b001, 1, 0, 0, 1, 0, 64'h10, 0, 0);
        vecs[3]  = mk(1, 0, 64'h11, 3'b000, 1, 3'b001, 2, 0, 0, 1, 0, 64'h10, 0, 0);
        vecs[4]  = mk(1, 0, 64'h12, 3'b000, 1, 3'b001, 3, 0, 0, 1, 0, 64'h10, 0, 0);
        vecs[5]  = mk(1, 0, 64'h13, 3'b000, 1, 3'b001, 4, 0, 0, 1, 0, 64'h10, 0, 0);
        vecs[6]  = mk(1, 0, 64'h14, 3'b000, 0, 3'b001, 4, 0, 0, 1, 0, 64'h10, 0, 0);
        vecs[7]  = mk(1, 2, 64'h20, 3'b000, 1, 3'b101, 4, 0, 1, 1, 2, 64'h20, 0, 0);
        vecs[8]  = mk(1, 0, 64'h14, 3'b001, 0, 3'b101, 3, 0, 1, 1, 0, 64'h11, 0, 0);
        vecs[9]  = mk(1, 0, 64'h14, 3'b001, 1, 3'b101, 3, 0, 1, 1, 0, 64'h12, 0, 0);
        vecs[10] = mk(1, 0, 64'h15, 3'b001, 1, 3'b101, 3, 0, 1, 1, 0, 64'h13, 0, 0);
        vecs[11] = mk(0, 0, 64'h00, 3'b001, 1, 3'b101, 2, 0, 1, 1, 0, 64'h14, 0, 0);
        vecs[12] = mk(0, 0, 64'h00, 3'b101, 1, 3'b001, 1, 0, 0, 1, 0, 64'h15, 0, 0);
        vecs[13] = mk(0, 0, 64'h00, 3'b001, 1, 3'b000, 0, 0, 0, 0, 0, 64'h00, 0, 0);
        vecs[14] = mk(1, 0, 64'h30, 3'b000, 1, 3'b001, 1, 0, 0, 1, 0, 64'h30, 0, 0);
        vecs[15] = mk(1, 1, 64'h31, 3'b001, 1, 3'b010, 0, 1, 0, 1, 1, 64'h31, 0, 0);
        vecs[16] = mk(1, 2, 64'h32, 3'b010, 1, 3'b100, 0, 0, 1, 1, 2, 64'h32, 0, 0);
        vecs[17] = mk(1, 0, 64'h33, 3'b000, 1, 3'b101, 1, 0, 1, 1, 0, 64'h33, 0, 0);
        vecs[18] = mk(1, 0, 64'h34, 3'b101, 1, 3'b001, 1, 0, 0, 1, 0, 64'h34, 0, 0);
        vecs[19] = mk(0, 0, 64'h00, 3'b001, 1, 3'b000, 0, 0, 0, 0, 0, 64'h00, 0, 0);
        vecs[20] = mk(1, 3, 64'h40, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0, 64'h00, 1, 1);
        vecs[21] = mk(1, 3, 64'h41, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0, 64'h00, 1, 2);
        vecs[22] = mk(0, 3, 64'h42, 3'b000, 1, 3'b000, 0, 0, 0, 0, 0, 64'h00, 1, 2);

        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].v, vecs[i].vn, vecs[i].flit, vecs[i].rdy);
            #1;
            chk($sformatf("v%0d_ready", i), {63'd0, in_rdy}, {63'd0, vecs[i].e_ready});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {61'd0, out_vld}, {61'd0, vecs[i].e_valid});
            chk($sformatf("v%0d_occ", i),   {55'd0, occ_o},   {55'd0, vecs[i].e_occ});
            chk($sformatf("v%0d_err", i),   {63'd0, err_o},   {63'd0, vecs[i].e_err});
            chk($sformatf("v%0d_drop", i),  {48'd0, drop_o},  {48'd0, vecs[i].e_drop});
            if (vecs[i].ck) chk_head($sformatf("v%0d_head", i), int'(vecs[i].ck_vn), vecs[i].e_flit);
        end

        // Reset with VN0 holding three entries and a push in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 64'h50 + 64'(i), 3'b000);
            @(posedge clk);
            #1;
        end
        chk("pre_rst_occ0", {61'd0, occ_o[2:0]}, 64'd3);
        rst = 1'b1;
        drive(1'b1, 2'd0, 64'h53, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 2'd0, 64'd0, 3'b000);
        chk("midrst_valid", {61'd0, out_vld}, 64'd0);
        chk("midrst_occ",   {55'd0, occ_o}, 64'd0);
        chk("midrst_err",   {63'd0, err_o}, 64'd0);
        chk("midrst_drop",  {48'd0, drop_o}, 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_idle_valid", {61'd0, out_vld}, 64'd0);

        // Random ids, valids and consumer readies against per-VN queues.
        seq = 32'h100;
        drops = 0;
        for (int c = 0; c < 200; c++) begin
            logic       v;
            logic [1:0] vn;
            logic [2:0] rdy;
            logic       e_rdy;
            v   = 1'($urandom_range(0, 1));
            vn  = 2'($urandom_range(0, 3));
            rdy = 3'($urandom_range(0, 7));
            drive(v, vn, 64'(seq), rdy);
            #1;
            e_rdy = (vn == 2'd3) || (q[int'(vn)].size() < 4);
            chk($sformatf("rnd%0d_ready", c), {63'd0, in_rdy}, {63'd0, e_rdy});
            for (int k = 0; k < NV; k++) begin
                chk($sformatf("rnd%0d_valid%0d", c, k), {63'd0, out_vld[k]},
                    {63'd0, q[k].size() != 0});
                if (q[k].size() != 0) chk_head($sformatf("rnd%0d_head%0d", c, k), k, q[k][0]);
            end
            @(posedge clk);
            for (int k = 0; k < NV; k++) begin
                if (q[k].size() != 0 && rdy[k]) void'(q[k].pop_front());
            end
            if (v && e_rdy) begin
                if (vn == 2'd3) drops++;
                else q[int'(vn)].push_back(64'(seq));
            end
            seq++;
            #1;
            for (int k = 0; k < NV; k++) begin
                chk($sformatf("rnd%0d_occ%0d", c, k), {61'd0, occ_o[k*CW +: CW]},
                    64'(q[k].size()));
            end
            chk($sformatf("rnd%0d_drop", c), {48'd0, drop_o}, 64'(drops));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
